pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the 5-stage MIPS core; replaces the hand-written F/D, D/E, E/M, M/W regs.
//  Carries an opaque control/data payload, the instruction PC, a valid bit and the hazard-unit T_new field.
//  Supports stall (hold), flush (bubble insert) and a saturating T_new decrement.
//  PC is kept on bubbles so later stages (exception/EPC logic) always see a meaningful PC.
// PARAMETERS
//  PAYLOAD_W       128            width of opaque payload bus (regs data, imm, addrs, CU signals)
//  TNEW_W          2              width of T_new field
//  TNEW_DEC        1              amount subtracted from T_new per stage crossing (0 = pass through)
//  RESET_PC        32'h0000_3000  out_pc value after reset
//  KEEP_PC_ON_CLR  1              1: a flush captures in_pc; 0: a flush loads RESET_PC
// PORTS
//  clk          in   1          clock, all state updates on posedge
//  reset        in   1          synchronous, active-high
//  en           in   1          stage enable; 0 = stall (hold contents)
//  clr          in   1          flush; inserts a bubble
//  in_valid     in   1          upstream instruction is real (not bubble)
//  in_payload   in   PAYLOAD_W  upstream payload
//  in_pc        in   32         upstream PC
//  in_tnew      in   TNEW_W     upstream T_new
//  out_valid    out  1          registered valid
//  out_payload  out  PAYLOAD_W  registered payload
//  out_pc       out  32         registered PC
//  out_tnew     out  TNEW_W     registered, decremented T_new
// BEHAVIOUR
//  - All outputs registered; latency 1 cycle from in_* to out_* when en=1, clr=0.
//  - Priority per posedge: reset > clr > en > hold.
//  - reset: out_valid=0, out_payload=0, out_tnew=0, out_pc=RESET_PC.
//  - clr (regardless of en): out_valid=0, out_payload=0, out_tnew=0, out_pc=KEEP_PC_ON_CLR ? in_pc : RESET_PC.
//    clr&!en (stall+flush same cycle) is a flush; the flush wins.
//  - en&!clr&in_valid: out_valid=1, out_payload=in_payload, out_pc=in_pc,
//    out_tnew = (in_tnew > TNEW_DEC) ? in_tnew-TNEW_DEC : 0.
//    Unsigned compare in TNEW_W bits; never wraps below 0.
//  - en&!clr&!in_valid: bubble as for clr, but out_pc=in_pc always.
//    Payload is zeroed, so a bubble never asserts any write enable downstream.
//  - !en&!clr: all outputs hold; out_tnew is NOT decremented while held.
//  - Held contents survive any number of stall cycles; reset mid-stall clears per reset rule.
//  - TNEW_DEC=0: out_tnew=in_tnew for valid captures.
//  - TNEW_DEC >= 2**TNEW_W: every valid capture gives out_tnew=0.
// CONFIGURATION
//  Macro PIPE_STAGE_STAT_EN
//  - Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0], both registered and saturating at 32'hFFFF_FFFF.
//    Both are 0 on reset and are not cleared by clr.
//    stall_cnt increments each cycle with !en&!clr&out_valid (real instruction held).
//    bubble_cnt increments each cycle a bubble is captured (clr, or en&!in_valid).
//  - Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Reset: drive reset=1 1 cycle, any inputs -> out_valid=0, out_payload=0, out_tnew=0, out_pc=32'h0000_3000.
//  2 Pass: en=1, in_valid=1, in_pc=32'h3004, in_tnew=2, payload=128'hA5.. -> next cycle out_pc=3004, out_tnew=1, payload equal.
//    Repeat with in_tnew=0 -> out_tnew=0 (no wrap).
//  3 Stall: capture pc=3008, then en=0 for 3 cycles with changing inputs -> outputs frozen at 3008 and tnew unchanged.
//    Then en=1 -> new data next cycle.
//  4 Flush under stall: en=0, clr=1, in_pc=300C -> out_valid=0, payload=0, tnew=0, out_pc=300C.
//    With KEEP_PC_ON_CLR=0 -> out_pc=3000.
//  5 Priority: reset=1, clr=1, en=1 same cycle -> reset values, not the flush values.
//  6 PIPE_STAGE_STAT_EN: 4 stall cycles with a valid held, then 2 flush cycles -> stall_cnt=4, bubble_cnt=2.
//    Preload stall_cnt=FFFF_FFFF via force, stall 1 cycle -> stall_cnt stays FFFF_FFFF.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register for the 5-stage MIPS core.
// Carries an opaque payload, the instruction PC, a valid bit and the hazard-unit
// T_new field. Supports stall (hold), flush (bubble insert) and a saturating
// T_new decrement on every valid capture.
// Optional feature: define PIPE_STAGE_STAT_EN to add the stall_cnt / bubble_cnt
// statistics outputs. With the macro undefined those ports and counters are absent.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W      = 128,
    parameter int unsigned TNEW_W         = 2,
    parameter int unsigned TNEW_DEC       = 1,
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter bit          KEEP_PC_ON_CLR = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [31:0]          in_pc,
    input  logic [TNEW_W-1:0]    in_tnew,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          out_pc,
    output logic [TNEW_W-1:0]    out_tnew
`ifdef PIPE_STAGE_STAT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);

    // A decrement at least as large as the field's range always saturates to zero,
    // so it is resolved at elaboration and the run-time compare stays TNEW_W wide.
    localparam bit              DEC_SATURATES = (64'(TNEW_DEC) >= (64'd1 << TNEW_W));
    localparam logic [TNEW_W-1:0] DEC_AMT     = DEC_SATURATES ? '0 : TNEW_DEC[TNEW_W-1:0];

    logic                 valid_reg,   valid_next;
    logic [PAYLOAD_W-1:0] payload_reg, payload_next;
    logic [31:0]          pc_reg,      pc_next;
    logic [TNEW_W-1:0]    tnew_reg,    tnew_next;
    logic [TNEW_W-1:0]    tnew_dec;

    // Saturating T_new decrement; never wraps below zero.
    always_comb begin
        tnew_dec = '0;
        if (!DEC_SATURATES && (in_tnew > DEC_AMT)) begin
            tnew_dec = in_tnew - DEC_AMT;
        end
    end

    // Next-state selection: flush beats enable, enable beats hold.
    always_comb begin
        valid_next   = valid_reg;
        payload_next = payload_reg;
        pc_next      = pc_reg;
        tnew_next    = tnew_reg;
        if (clr) begin
            // Flush: bubble, PC either kept from upstream or parked at the reset vector.
            valid_next   = 1'b0;
            payload_next = '0;
            tnew_next    = '0;
            pc_next      = KEEP_PC_ON_CLR ? in_pc : RESET_PC;
        end else if (en) begin
            // Upstream PC is always kept so EPC logic downstream sees a real address.
            pc_next = in_pc;
            if (in_valid) begin
                valid_next   = 1'b1;
                payload_next = in_payload;
                tnew_next    = tnew_dec;
            end else begin
                // Zeroed payload guarantees a bubble never asserts a write enable.
                valid_next   = 1'b0;
                payload_next = '0;
                tnew_next    = '0;
            end
        end
    end

    // Stage registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg   <= 1'b0;
            payload_reg <= '0;
            pc_reg      <= RESET_PC;
            tnew_reg    <= '0;
        end else begin
            valid_reg   <= valid_next;
            payload_reg <= payload_next;
            pc_reg      <= pc_next;
            tnew_reg    <= tnew_next;
        end
    end

    assign out_valid   = valid_reg;
    assign out_payload = payload_reg;
    assign out_pc      = pc_reg;
    assign out_tnew    = tnew_reg;

`ifdef PIPE_STAGE_STAT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] bubble_cnt_reg;
    logic        stall_evt;
    logic        bubble_evt;

    // A stall is only counted while a real instruction is being held.
    assign stall_evt  = !en && !clr && valid_reg;
    assign bubble_evt = clr || (en && !in_valid);

    // Saturating statistics counters; cleared only by reset, never by a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (stall_evt && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (bubble_evt && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a table of per-cycle vectors whose
// expected outputs are pushed to a scoreboard queue when driven and popped after
// the capturing edge. A second instance checks KEEP_PC_ON_CLR=0 and an
// over-range TNEW_DEC. Statistics counters are exercised when PIPE_STAGE_STAT_EN
// is defined.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset, en, clr, in_valid;
    logic [127:0] in_payload;
    logic [31:0]  in_pc;
    logic [1:0]   in_tnew;

    logic         a_valid, b_valid;
    logic [127:0] a_payload, b_payload;
    logic [31:0]  a_pc, b_pc;
    logic [1:0]   a_tnew, b_tnew;
`ifdef PIPE_STAGE_STAT_EN
    logic [31:0]  a_stall_cnt, a_bubble_cnt, b_stall_cnt, b_bubble_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid),
        .in_payload(in_payload), .in_pc(in_pc), .in_tnew(in_tnew),
        .out_valid(a_valid), .out_payload(a_payload), .out_pc(a_pc), .out_tnew(a_tnew)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
`endif
    );

    pipe_stage_reg #(.TNEW_DEC(4), .KEEP_PC_ON_CLR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .in_valid(in_valid),
        .in_payload(in_payload), .in_pc(in_pc), .in_tnew(in_tnew),
        .out_valid(b_valid), .out_payload(b_payload), .out_pc(b_pc), .out_tnew(b_tnew)
`ifdef PIPE_STAGE_STAT_EN
        , .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
`endif
    );

    typedef struct {
        logic         rst, en, clr, iv;
        logic [127:0] pay;
        logic [31:0]  pc;
        logic [1:0]   tn;
        logic         e_v;
        logic [127:0] e_pay;
        logic [31:0]  e_pc;
        logic [1:0]   e_tn;
        logic [31:0]  e_bpc;
        logic [1:0]   e_btn;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [127:0] P1 = {16{8'hA5}};
    localparam logic [127:0] P2 = {4{32'hDEAD_BEEF}};
    localparam logic [127:0] P3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] P4 = 128'h1;

    function automatic vec_t mk(input logic rst, input logic e, input logic c, input logic iv,
                                input logic [127:0] pay, input logic [31:0] pc, input logic [1:0] tn,
                                input logic ev, input logic [127:0] epay, input logic [31:0] epc,
                                input logic [1:0] etn, input logic [31:0] ebpc, input logic [1:0] ebtn);
        vec_t v;
        v.rst = rst; v.en = e; v.clr = c; v.iv = iv; v.pay = pay; v.pc = pc; v.tn = tn;
        v.e_v = ev; v.e_pay = epay; v.e_pc = epc; v.e_tn = etn; v.e_bpc = ebpc; v.e_btn = ebtn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp_v);
        end
    endtask

    task automatic drive(input logic rst, input logic e, input logic c, input logic iv,
                         input logic [127:0] pay, input logic [31:0] pc, input logic [1:0] tn);
        @(negedge clk);
        reset = rst; en = e; clr = c; in_valid = iv; in_payload = pay; in_pc = pc; in_tnew = tn;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_payload = '0; in_pc = '0; in_tnew = '0;

        //         rst en clr iv  pay  pc          tn   | v  pay pc          tn | b_pc        b_tn
        vecs.push_back(mk(1, 1, 0, 1, P1, 32'h3FFC, 2'd3, 0, '0, 32'h3000, 2'd0, 32'h3000, 2'd0)); // reset
        vecs.push_back(mk(0, 1, 0, 1, P1, 32'h3004, 2'd2, 1, P1, 32'h3004, 2'd1, 32'h3004, 2'd0)); // pass
        vecs.push_back(mk(0, 1, 0, 1, P2, 32'h3008, 2'd0, 1, P2, 32'h3008, 2'd0, 32'h3008, 2'd0)); // no wrap
        vecs.push_back(mk(0, 1, 0, 1, P3, 32'h300C, 2'd3, 1, P3, 32'h300C, 2'd2, 32'h300C, 2'd0));
        vecs.push_back(mk(0, 1, 0, 1, P1, 32'h3010, 2'd1, 1, P1, 32'h3010, 2'd0, 32'h3010, 2'd0)); // equal -> 0
        vecs.push_back(mk(0, 1, 0, 1, P2, 32'h3008, 2'd3, 1, P2, 32'h3008, 2'd2, 32'h3008, 2'd0)); // capture 3008
        vecs.push_back(mk(0, 0, 0, 1, P3, 32'h4000, 2'd0, 1, P2, 32'h3008, 2'd2, 32'h3008, 2'd0)); // stall 1
        vecs.push_back(mk(0, 0, 0, 0, P4, 32'h4004, 2'd1, 1, P2, 32'h3008, 2'd2, 32'h3008, 2'd0)); // stall 2
        vecs.push_back(mk(0, 0, 0, 1, P1, 32'h4008, 2'd3, 1, P2, 32'h3008, 2'd2, 32'h3008, 2'd0)); // stall 3
        vecs.push_back(mk(0, 1, 0, 1, P4, 32'h3014, 2'd2, 1, P4, 32'h3014, 2'd1, 32'h3014, 2'd0)); // resume
        vecs.push_back(mk(0, 0, 1, 1, P1, 32'h300C, 2'd3, 0, '0, 32'h300C, 2'd0, 32'h3000, 2'd0)); // flush+stall
        vecs.push_back(mk(0, 0, 0, 1, P2, 32'h5000, 2'd2, 0, '0, 32'h300C, 2'd0, 32'h3000, 2'd0)); // hold bubble
        vecs.push_back(mk(0, 1, 0, 0, P3, 32'h3018, 2'd3, 0, '0, 32'h3018, 2'd0, 32'h3018, 2'd0)); // en bubble
        vecs.push_back(mk(0, 1, 0, 1, P1, 32'h301C, 2'd2, 1, P1, 32'h301C, 2'd1, 32'h301C, 2'd0));
        vecs.push_back(mk(0, 1, 1, 1, P2, 32'h3020, 2'd3, 0, '0, 32'h3020, 2'd0, 32'h3000, 2'd0)); // flush+en
        vecs.push_back(mk(0, 1, 0, 1, P2, 32'h3024, 2'd3, 1, P2, 32'h3024, 2'd2, 32'h3024, 2'd0));
        vecs.push_back(mk(1, 1, 1, 1, P3, 32'h3028, 2'd3, 0, '0, 32'h3000, 2'd0, 32'h3000, 2'd0)); // priority
        vecs.push_back(mk(0, 1, 0, 1, P3, 32'h302C, 2'd2, 1, P3, 32'h302C, 2'd1, 32'h302C, 2'd0));
        vecs.push_back(mk(0, 0, 0, 0, P1, 32'h6000, 2'd0, 1, P3, 32'h302C, 2'd1, 32'h302C, 2'd0)); // stall
        vecs.push_back(mk(1, 0, 0, 1, P1, 32'h6004, 2'd3, 0, '0, 32'h3000, 2'd0, 32'h3000, 2'd0)); // reset mid-stall
        vecs.push_back(mk(0, 0, 0, 1, P2, 32'h6008, 2'd3, 0, '0, 32'h3000, 2'd0, 32'h3000, 2'd0)); // hold reset
        vecs.push_back(mk(0, 1, 1, 0, P4, 32'h3030, 2'd1, 0, '0, 32'h3030, 2'd0, 32'h3000, 2'd0)); // clr, iv=0

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v, e;
            v = vecs[i];
            @(negedge clk);
            reset = v.rst; en = v.en; clr = v.clr; in_valid = v.iv;
            in_payload = v.pay; in_pc = v.pc; in_tnew = v.tn;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("out_valid",   i, 128'(a_valid),  128'(e.e_v));
            chk("out_payload", i, a_payload,      e.e_pay);
            chk("out_pc",      i, 128'(a_pc),     128'(e.e_pc));
            chk("out_tnew",    i, 128'(a_tnew),   128'(e.e_tn));
            chk("b_valid",     i, 128'(b_valid),  128'(e.e_v));
            chk("b_pc",        i, 128'(b_pc),     128'(e.e_bpc));
            chk("b_tnew",      i, 128'(b_tnew),   128'(e.e_btn));
            $display("vec %0d rst=%0b en=%0b clr=%0b iv=%0b pc=%h -> v=%0b pc=%h tnew=%0d b_pc=%h",
                     i, v.rst, v.en, v.clr, v.iv, v.pc, a_valid, a_pc, a_tnew, b_pc);
        end
        chk("scoreboard_empty", 0, 128'(sb.size()), 128'd0);

`ifdef PIPE_STAGE_STAT_EN
        drive(1, 0, 0, 0, '0, 32'h0, 2'd0);
        chk("stall_cnt_reset",  100, 128'(a_stall_cnt),  128'd0);
        chk("bubble_cnt_reset", 100, 128'(a_bubble_cnt), 128'd0);
        drive(0, 1, 0, 1, P1, 32'h3100, 2'd2);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, P2, 32'h7000, 2'd1);
        chk("stall_cnt_4", 101, 128'(a_stall_cnt), 128'd4);
        for (int k = 0; k < 2; k++) drive(0, 0, 1, 1, P3, 32'h3104, 2'd3);
        chk("stall_cnt_after_flush", 102, 128'(a_stall_cnt),  128'd4);
        chk("bubble_cnt_2",          102, 128'(a_bubble_cnt), 128'd2);
        $display("stat stall_cnt=%0d bubble_cnt=%0d", a_stall_cnt, a_bubble_cnt);
        drive(0, 1, 0, 1, P1, 32'h3108, 2'd2);
        @(negedge clk);
        force dut.stall_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_reg;
        drive(0, 0, 0, 1, P2, 32'h7004, 2'd0);
        chk("stall_cnt_saturate", 103, 128'(a_stall_cnt),  128'hFFFF_FFFF);
        chk("bubble_cnt_hold",    103, 128'(a_bubble_cnt), 128'd2);
        $display("stat saturate stall_cnt=%h", a_stall_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
